// File: rtl/compress_pipeline_pkg.sv
// rtl/compress_pipeline_pkg.sv - compress_types package: default sizes, stage records, residual width helper
package compress_types;

    localparam int DEF_NUM_PIX    = 8;
    localparam int DEF_PIX_W      = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_W_W        = $clog2(DEF_PIX_W + 2);

    typedef logic [DEF_PIX_W-1:0] pixel_t;
    typedef logic signed [DEF_PIX_W:0] residual_t;

    typedef struct packed {
        logic                               valid;
        logic [DEF_NUM_PIX*DEF_PIX_W-1:0]   pixels;
    } hdr_stage_t;

    typedef struct packed {
        pixel_t                                 base;
        logic [DEF_W_W-1:0]                     width;
        logic                                   raw;
        logic [DEF_NUM_PIX*(DEF_PIX_W+1)-1:0]   residuals;
    } res_stage_t;

    // Smallest two's-complement width in 1..max_w that holds r; saturates at max_w.
    function automatic int min_res_width(input int r, input int max_w);
        int w;
        int lim;
        w = max_w;
        for (int k = 31; k >= 1; k--) begin
            lim = 1 << (k - 1);
            if ((k <= max_w) && (r >= -lim) && (r <= lim - 1)) begin
                w = k;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/compress_pipeline_out_fifo.sv
// rtl/compress_pipeline_out_fifo.sv - compress_out_fifo: synchronous FIFO of residual-stage records holding last head
module compress_out_fifo
    import compress_types::*;
#(
    parameter type T     = res_stage_t,
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    parameter int  CNT_W = $clog2(DEF_FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output T                 head
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    T                 last_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage, power-of-two wrapping pointers, occupancy and the last popped entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            last_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // When empty, present the most recently popped entry so outputs hold.
    always_comb begin
        head = last_q;
        if (count != '0) begin
            head = mem[rd_ptr];
        end
        full = (count == CNT_W'(DEPTH));
    end

endmodule

// File: rtl/compress_pipeline.sv
// rtl/compress_pipeline.sv - compress_pipeline top: header/residual stages into credit-gated FIFO; COMPRESS_STATS_EN adds pop counters
module compress_pipeline
    import compress_types::*;
#(
    parameter int NUM_PIX    = DEF_NUM_PIX,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int W_W        = $clog2(PIX_W + 2)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_PIX*PIX_W-1:0]       in_pixels,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PIX_W-1:0]               out_base,
    output logic [W_W-1:0]                 out_width,
    output logic                           out_raw,
`ifdef COMPRESS_STATS_EN
    output logic [31:0]                    stat_blocks,
    output logic [31:0]                    stat_raw,
`endif
    output logic [NUM_PIX*(PIX_W+1)-1:0]   out_residuals
);

    localparam int RES_W = PIX_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic                       valid;
        logic [NUM_PIX*PIX_W-1:0]   pixels;
    } hdr_t;

    typedef struct packed {
        logic [PIX_W-1:0]           base;
        logic [W_W-1:0]             width;
        logic                       raw;
        logic [NUM_PIX*RES_W-1:0]   residuals;
    } res_t;

    hdr_t                       hdr;
    res_t                       r_data;
    logic                       r_valid;
    res_t                       head;
    logic                       fifo_full;
    logic [CNT_W-1:0]           fifo_count;
    logic                       accept;
    logic                       pop;

    logic [PIX_W-1:0]           calc_base;
    logic [NUM_PIX*RES_W-1:0]   calc_res;
    logic [NUM_PIX*RES_W-1:0]   calc_zext;
    logic signed [RES_W-1:0]    diff;
    int                         lane_w;
    int                         calc_w;
    logic                       calc_raw;

    // Credits count every block already committed downstream, so the FIFO can never overflow.
    always_comb begin
        in_ready = rst && !fifo_full &&
                   ((int'(fifo_count) + int'(hdr.valid) + int'(r_valid)) < FIFO_DEPTH);
        accept   = in_valid && in_ready;
        out_valid = (fifo_count != '0);
        pop      = out_valid && out_ready;
    end

    // Header stage: capture the accepted block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr <= '0;
        end else begin
            hdr.valid <= accept;
            if (accept) begin
                hdr.pixels <= in_pixels;
            end
        end
    end

    // Exact signed residuals against pixel 0 and the widest lane requirement.
    always_comb begin
        calc_base = hdr.pixels[PIX_W-1:0];
        calc_res  = '0;
        calc_zext = '0;
        diff      = '0;
        lane_w    = 1;
        calc_w    = 1;
        for (int i = 0; i < NUM_PIX; i++) begin
            diff   = $signed({1'b0, hdr.pixels[i*PIX_W +: PIX_W]}) - $signed({1'b0, calc_base});
            lane_w = min_res_width(int'(diff), RES_W);
            if (lane_w > calc_w) begin
                calc_w = lane_w;
            end
            calc_res[i*RES_W +: RES_W]  = diff;
            calc_zext[i*RES_W +: RES_W] = {1'b0, hdr.pixels[i*PIX_W +: PIX_W]};
        end
        calc_raw = (calc_w >= PIX_W);
    end

    // Residual stage: choose coded or raw representation; never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= hdr.valid;
            if (hdr.valid) begin
                r_data.base      <= calc_base;
                r_data.raw       <= calc_raw;
                r_data.width     <= calc_raw ? W_W'(PIX_W) : W_W'(calc_w);
                r_data.residuals <= calc_raw ? calc_zext : calc_res;
            end
        end
    end

    compress_out_fifo #(
        .T     (res_t),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_valid),
        .push_data (r_data),
        .pop       (pop),
        .full      (fifo_full),
        .count     (fifo_count),
        .head      (head)
    );

    // Output fields come straight from the FIFO head register.
    always_comb begin
        out_base      = head.base;
        out_width     = head.width;
        out_raw       = head.raw;
        out_residuals = head.residuals;
    end

`ifdef COMPRESS_STATS_EN
    // Saturating counts of delivered blocks and of raw blocks among them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_blocks <= '0;
            stat_raw    <= '0;
        end else if (pop) begin
            if (stat_blocks != '1) begin
                stat_blocks <= stat_blocks + 32'd1;
            end
            if (head.raw && (stat_raw != '1)) begin
                stat_raw <= stat_raw + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_compress_pipeline.sv
// tb/tb_compress_pipeline.sv - directed table-driven bench for compress_pipeline
module tb_compress_pipeline;

    localparam int NP  = 8;
    localparam int PW  = 8;
    localparam int RW  = PW + 1;
    localparam int NV  = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [NP*PW-1:0]  in_pixels;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     out_base;
    logic [3:0]        out_width;
    logic              out_raw;
    logic [NP*RW-1:0]  out_residuals;
`ifdef COMPRESS_STATS_EN
    logic [31:0]       stat_blocks;
    logic [31:0]       stat_raw;
`endif

    compress_pipeline dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pixels     (in_pixels),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_base      (out_base),
        .out_width     (out_width),
        .out_raw       (out_raw),
`ifdef COMPRESS_STATS_EN
        .stat_blocks   (stat_blocks),
        .stat_raw      (stat_raw),
`endif
        .out_residuals (out_residuals)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pix[NP];
        int base;
        int width;
        int raw;
        int res[NP];
    } vec_t;

    vec_t vecs[NV];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [NP*PW-1:0] pack_pix(input int k);
        logic [NP*PW-1:0] p;
        for (int i = 0; i < NP; i++) p[i*PW +: PW] = PW'(vecs[k].pix[i]);
        return p;
    endfunction

    function automatic logic [NP*RW-1:0] pack_res(input int k);
        logic [NP*RW-1:0] r;
        for (int i = 0; i < NP; i++) r[i*RW +: RW] = RW'(vecs[k].res[i]);
        return r;
    endfunction

    task automatic check_out(input int k);
        chk("base",      128'(out_base),      128'(vecs[k].base));
        chk("width",     128'(out_width),     128'(vecs[k].width));
        chk("raw",       128'(out_raw),       128'(vecs[k].raw));
        chk("residuals", 128'(out_residuals), 128'(pack_res(k)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single block with out_ready high: latency, contents, then hold after pop.
    task automatic send_vec(input int k);
        int n;
        in_valid  = 1'b1;
        in_pixels = pack_pix(k);
        chk("in_ready_idle", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            tick();
            n++;
        end
        chk("latency", 128'(n), 128'(3));
        check_out(k);
        tick();
        chk("empty_after_pop", 128'(out_valid), 128'(0));
        chk("hold_base", 128'(out_base), 128'(vecs[k].base));
        chk("hold_res", 128'(out_residuals), 128'(pack_res(k)));
    endtask

    // Stream nblk blocks; out_ready low for the first stall cycles.
    task automatic stream(input int nblk, input int stall, input bit chk_tput);
        int sent, rcv, cyc, first_out, last_out, acc_at_stall;
        bit acc;
        sent = 0; rcv = 0; cyc = 0; first_out = -1; last_out = -1; acc_at_stall = -1;
        while (rcv < nblk && cyc < 300) begin
            out_ready = (cyc >= stall);
            if (cyc == stall) acc_at_stall = sent;
            if (stall > 0 && cyc == stall - 1) chk("in_ready_full", 128'(in_ready), 128'(0));
            in_valid  = (sent < nblk);
            in_pixels = pack_pix(sent % NV);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check_out(rcv % NV);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                rcv++;
            end else if (out_valid && !out_ready && rcv == 0) begin
                chk("stall_head_base", 128'(out_base), 128'(vecs[0].base));
            end
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 128'(rcv), 128'(nblk));
        if (stall > 0) chk("accepts_at_full", 128'(acc_at_stall), 128'(4));
        if (chk_tput) chk("throughput_span", 128'(last_out - first_out), 128'(nblk - 1));
        for (int i = 0; i < 5; i++) tick();
        chk("no_extra_output", 128'(out_valid), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{'{100,100,100,100,100,100,100,100}, 100, 1, 0, '{0,0,0,0,0,0,0,0}};
        vecs[1] = '{'{100,101,99,100,102,98,100,100},   100, 3, 0, '{0,1,-1,0,2,-2,0,0}};
        vecs[2] = '{'{0,255,0,0,0,0,0,0},               0,   8, 1, '{0,255,0,0,0,0,0,0}};
        vecs[3] = '{'{50,50,51,50,50,50,50,50},         50,  2, 0, '{0,0,1,0,0,0,0,0}};
        vecs[4] = '{'{10,9,10,10,10,10,10,10},          10,  1, 0, '{0,-1,0,0,0,0,0,0}};
        vecs[5] = '{'{0,63,0,0,0,0,0,0},                0,   7, 0, '{0,63,0,0,0,0,0,0}};
        vecs[6] = '{'{64,0,64,64,64,64,64,64},          64,  7, 0, '{0,-64,0,0,0,0,0,0}};
        vecs[7] = '{'{0,64,0,0,0,0,0,0},                0,   8, 1, '{0,64,0,0,0,0,0,0}};
        vecs[8] = '{'{255,0,255,255,255,255,255,255},   255, 8, 1, '{255,0,255,255,255,255,255,255}};

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pixels = '0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_in_ready",  128'(in_ready),      128'(0));
        chk("rst_out_valid", 128'(out_valid),     128'(0));
        chk("rst_base",      128'(out_base),      128'(0));
        chk("rst_width",     128'(out_width),     128'(0));
        chk("rst_raw",       128'(out_raw),       128'(0));
        chk("rst_res",       128'(out_residuals), 128'(0));
        rst = 1'b1;
        #1;
        chk("release_in_ready", 128'(in_ready), 128'(1));

        out_ready = 1'b1;
        for (int k = 0; k < NV; k++) send_vec(k);

        stream(6, 8, 1'b0);
        stream(20, 0, 1'b1);

        // Reset with two blocks in the FIFO and both stages occupied.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'b1;
            in_pixels = pack_pix(k);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_reset_out_valid", 128'(out_valid), 128'(1));
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid),     128'(0));
        chk("mid_rst_in_ready",  128'(in_ready),      128'(0));
        chk("mid_rst_base",      128'(out_base),      128'(0));
        chk("mid_rst_width",     128'(out_width),     128'(0));
        chk("mid_rst_res",       128'(out_residuals), 128'(0));
        tick();
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        send_vec(1);
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_no_ghost", 128'(out_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
